// File: rtl/lc3_mem_pkg.sv
// Shared types and constants for the LC-3 SRAM read path.
package lc3_mem_pkg;

  localparam int unsigned MEM_AW       = 20;
  localparam int unsigned MEM_DW       = 16;
  localparam int unsigned MEM_WAIT_MAX = 15;

  typedef enum logic [1:0] {IDLE, SETUP, WAIT, RESP} rd_state_t;

  // Wait-counter load value; out-of-range requests are clamped into 1..MEM_WAIT_MAX.
  function automatic logic [3:0] wait_load(input int unsigned cycles);
    int unsigned c;
    c = (cycles < 1) ? 1 : ((cycles > MEM_WAIT_MAX) ? MEM_WAIT_MAX : cycles);
    return 4'(c - 1);
  endfunction

endpackage

// File: rtl/req_fifo.sv
// Two-entry request FIFO with a registered occupancy count.
module req_fifo #(
  parameter int unsigned W = 20
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);

  logic [W-1:0] mem_q [2];
  logic         rd_ptr_q;
  logic         wr_ptr_q;
  logic [1:0]   count_q;
  logic         do_push;
  logic         do_pop;

  assign full    = (count_q == 2'd2);
  assign empty   = (count_q == 2'd0);
  assign head    = mem_q[rd_ptr_q];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= din;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/mem_read_sequencer.sv
// Queued word-read sequencer driving an asynchronous SRAM's active-low read cycle and
// returning captured data on a valid/ready response port.
module mem_read_sequencer
  import lc3_mem_pkg::*;
#(
  parameter int unsigned AW          = MEM_AW,
  parameter int unsigned DW          = MEM_DW,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          Req_Valid,
  input  logic [AW-1:0] Req_Addr,
  output logic          Req_Ready,
  output logic          Rsp_Valid,
  output logic [DW-1:0] Rsp_Data,
  input  logic          Rsp_Ready,
  output logic          Busy,
  output logic [AW-1:0] Mem_Addr,
  output logic          Mem_CE_N,
  output logic          Mem_OE_N,
  output logic          Mem_WE_N,
  output logic          Mem_UB_N,
  output logic          Mem_LB_N,
  input  logic [DW-1:0] Mem_Data_In
);

  localparam logic [3:0] WaitLoad = wait_load(WAIT_CYCLES);

  rd_state_t     state_q, state_d;
  logic [3:0]    wait_cnt_q, wait_cnt_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] rsp_data_q, rsp_data_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic          fifo_pop;
  logic          fifo_full;
  logic          fifo_empty;
  logic [AW-1:0] fifo_head;

  req_fifo #(
    .W (AW)
  ) u_req_fifo (
    .Clk   (Clk),
    .Reset (Reset),
    .push  (Req_Valid),
    .pop   (fifo_pop),
    .din   (Req_Addr),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (fifo_head)
  );

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q     <= IDLE;
      wait_cnt_q  <= 4'd0;
      mem_addr_q  <= '0;
      rsp_data_q  <= '0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      mem_addr_q  <= mem_addr_d;
      rsp_data_q  <= rsp_data_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    mem_addr_d  = mem_addr_q;
    rsp_data_d  = rsp_data_q;
    rsp_valid_d = rsp_valid_q;
    fifo_pop    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          mem_addr_d = fifo_head;
          state_d    = SETUP;
        end
      end
      SETUP: begin
        wait_cnt_d = WaitLoad;
        state_d    = WAIT;
      end
      WAIT: begin
        if (wait_cnt_q == 4'd0) begin
          rsp_data_d  = Mem_Data_In;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end else begin
          wait_cnt_d = wait_cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (Rsp_Ready) begin
          rsp_valid_d = 1'b0;
          // Chain straight into the next read to sustain one response per WAIT_CYCLES+2.
          if (!fifo_empty) begin
            fifo_pop   = 1'b1;
            mem_addr_d = fifo_head;
            state_d    = SETUP;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign Req_Ready = ~fifo_full;
  assign Rsp_Valid = rsp_valid_q;
  assign Rsp_Data  = rsp_data_q;
  assign Busy      = (state_q != IDLE) | ~fifo_empty;
  assign Mem_Addr  = mem_addr_q;
  assign Mem_CE_N  = ~((state_q == SETUP) | (state_q == WAIT));
  assign Mem_OE_N  = ~(state_q == WAIT);
  assign Mem_WE_N  = 1'b1;
  assign Mem_UB_N  = Mem_CE_N;
  assign Mem_LB_N  = Mem_CE_N;

endmodule

// File: tb/tb_mem_read_sequencer.sv
// Scoreboard bench for mem_read_sequencer: main instance at WAIT_CYCLES=2 plus latency
// instances at WAIT_CYCLES=1 and 15 sharing the clock and reset.
module tb_mem_read_sequencer;

  logic Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic        Reset;
  logic        req_valid, req_ready, rsp_valid, rsp_ready, busy;
  logic [19:0] req_addr, mem_addr;
  logic [15:0] rsp_data, mem_din;
  logic        ce_n, oe_n, we_n, ub_n, lb_n;

  logic        req_valid_1, req_ready_1, rsp_valid_1, busy_1;
  logic [19:0] req_addr_1, mem_addr_1;
  logic [15:0] rsp_data_1, mem_din_1;
  logic        ce_n_1, oe_n_1, we_n_1, ub_n_1, lb_n_1;

  logic        req_valid_15, req_ready_15, rsp_valid_15, busy_15;
  logic [19:0] req_addr_15, mem_addr_15;
  logic [15:0] rsp_data_15, mem_din_15;
  logic        ce_n_15, oe_n_15, we_n_15, ub_n_15, lb_n_15;

  // SRAM model: only drives data while chip and output are enabled.
  function automatic logic [15:0] sram(input logic [19:0] a);
    return (a == 20'h00123) ? 16'hBEEF : (a[15:0] ^ 16'hA5A5);
  endfunction

  assign mem_din    = (!ce_n && !oe_n) ? sram(mem_addr) : 16'h0000;
  assign mem_din_1  = (!ce_n_1 && !oe_n_1) ? sram(mem_addr_1) : 16'h0000;
  assign mem_din_15 = (!ce_n_15 && !oe_n_15) ? sram(mem_addr_15) : 16'h0000;

  mem_read_sequencer #(.AW(20), .DW(16), .WAIT_CYCLES(2)) dut (
    .Clk(Clk), .Reset(Reset), .Req_Valid(req_valid), .Req_Addr(req_addr),
    .Req_Ready(req_ready), .Rsp_Valid(rsp_valid), .Rsp_Data(rsp_data),
    .Rsp_Ready(rsp_ready), .Busy(busy), .Mem_Addr(mem_addr), .Mem_CE_N(ce_n),
    .Mem_OE_N(oe_n), .Mem_WE_N(we_n), .Mem_UB_N(ub_n), .Mem_LB_N(lb_n),
    .Mem_Data_In(mem_din)
  );

  mem_read_sequencer #(.AW(20), .DW(16), .WAIT_CYCLES(1)) dut_1 (
    .Clk(Clk), .Reset(Reset), .Req_Valid(req_valid_1), .Req_Addr(req_addr_1),
    .Req_Ready(req_ready_1), .Rsp_Valid(rsp_valid_1), .Rsp_Data(rsp_data_1),
    .Rsp_Ready(1'b1), .Busy(busy_1), .Mem_Addr(mem_addr_1), .Mem_CE_N(ce_n_1),
    .Mem_OE_N(oe_n_1), .Mem_WE_N(we_n_1), .Mem_UB_N(ub_n_1), .Mem_LB_N(lb_n_1),
    .Mem_Data_In(mem_din_1)
  );

  mem_read_sequencer #(.AW(20), .DW(16), .WAIT_CYCLES(15)) dut_15 (
    .Clk(Clk), .Reset(Reset), .Req_Valid(req_valid_15), .Req_Addr(req_addr_15),
    .Req_Ready(req_ready_15), .Rsp_Valid(rsp_valid_15), .Rsp_Data(rsp_data_15),
    .Rsp_Ready(1'b1), .Busy(busy_15), .Mem_Addr(mem_addr_15), .Mem_CE_N(ce_n_15),
    .Mem_OE_N(oe_n_15), .Mem_WE_N(we_n_15), .Mem_UB_N(ub_n_15), .Mem_LB_N(lb_n_15),
    .Mem_Data_In(mem_din_15)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int acc_cyc = 0;
  int rise_cnt = 0;
  int oe_cnt  = 0;
  int we_bad  = 0;
  int ublb_bad = 0;
  logic [15:0] exp_q[$];
  int          rise_cyc[$];
  logic [15:0] stream_exp[8] = '{16'hA585, 16'hA584, 16'hA587, 16'hA586,
                                 16'hA581, 16'hA580, 16'hA583, 16'hA582};

  always @(posedge Clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic timeout(input string name, input int limit);
    n_tests++;
    n_fail++;
    $display("FAIL %s: condition not met within %0d cycles (cycle %0d)", name, limit, cyc);
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic push(input logic [19:0] a, input logic [15:0] e);
    int g = 0;
    req_valid = 1'b1;
    req_addr  = a;
    while (!req_ready && g < 50) begin
      tick();
      g++;
    end
    if (!req_ready) timeout("push_ready", 50);
    exp_q.push_back(e);
    tick();
    acc_cyc   = cyc;
    req_valid = 1'b0;
  endtask

  task automatic drain(input int limit);
    int g = 0;
    while ((exp_q.size() != 0 || busy || rsp_valid) && g < limit) begin
      tick();
      g++;
    end
    check("drain_pending", exp_q.size(), 0);
    check("drain_busy", busy, 0);
  endtask

  // Monitor: pops the scoreboard on every response handshake and tracks pin activity.
  initial begin
    logic prev_valid = 1'b0;
    logic [15:0] e;
    forever begin
      @(negedge Clk);
      if (cyc > 1) begin
        if (we_n !== 1'b1 || we_n_1 !== 1'b1 || we_n_15 !== 1'b1) we_bad++;
        if (ub_n !== ce_n || lb_n !== ce_n) ublb_bad++;
      end
      if (Reset === 1'b1) begin
        if (rsp_valid && !prev_valid) begin
          rise_cyc.push_back(cyc);
          rise_cnt++;
        end
        if (!oe_n) oe_cnt++;
        if (rsp_valid && rsp_ready) begin
          if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL rsp_unexpected: got data 0x%0h, expected no response", rsp_data);
          end else begin
            e = exp_q.pop_front();
            check("rsp_data", rsp_data, e);
          end
        end
      end
      prev_valid = (Reset === 1'b1) && rsp_valid;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at cycle %0d, limit 10000", cyc);
    $fatal(1);
  end

  initial begin
    int g;
    int base;
    Reset = 1'b0;
    req_valid = 1'b1; req_addr = 20'h00777; rsp_ready = 1'b0;
    req_valid_1 = 1'b0; req_addr_1 = '0; req_valid_15 = 1'b0; req_addr_15 = '0;

    // 1: reset held with a request pending
    repeat (3) tick();
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_mem_n", {ce_n, oe_n, we_n, ub_n, lb_n}, 5'b11111);
    check("rst_busy", busy, 0);
    Reset = 1'b1;
    req_valid = 1'b0;
    tick();
    check("rst_req_ready", req_ready, 1);
    check("rst_busy_after", busy, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_rsp_data", rsp_data, 0);

    // 2: single read, latency and OE_N width
    rsp_ready = 1'b1;
    oe_cnt = 0;
    rise_cyc.delete();
    push(20'h00123, 16'hBEEF);
    base = acc_cyc;
    drain(40);
    if (rise_cyc.size() > 0) check("latency_wc2", rise_cyc[0] - base, 4);
    else timeout("latency_wc2", 40);
    check("oe_low_cycles", oe_cnt, 2);

    // 3: backpressure
    rsp_ready = 1'b0;
    push(20'h00010, 16'hA5B5);
    push(20'h00011, 16'hA5B4);
    push(20'h00012, 16'hA5B7);
    check("bp_req_ready_full", req_ready, 0);
    g = 0;
    while (!rsp_valid && g < 20) begin
      tick();
      g++;
    end
    if (!rsp_valid) timeout("bp_rsp_valid", 20);
    repeat (5) begin
      check("bp_hold_valid", rsp_valid, 1);
      check("bp_hold_data", rsp_data, 16'hA5B5);
      check("bp_hold_ready", req_ready, 0);
      tick();
    end
    rsp_ready = 1'b1;
    drain(60);

    // 4: streaming throughput
    rise_cyc.delete();
    for (int i = 0; i < 8; i++) push(20'h00020 + 20'(i), stream_exp[i]);
    drain(100);
    check("stream_count", rise_cyc.size(), 8);
    for (int i = 1; i < rise_cyc.size(); i++)
      check("stream_period", rise_cyc[i] - rise_cyc[i-1], 4);

    // 5: reset during WAIT with one request queued
    push(20'h00040, 16'hA5E5);
    push(20'h00041, 16'hA5E4);
    g = 0;
    while (oe_n && g < 20) begin
      tick();
      g++;
    end
    if (oe_n) timeout("midop_wait", 20);
    Reset = 1'b0;
    tick();
    exp_q.delete();
    check("midop_mem_n", {ce_n, oe_n, we_n, ub_n, lb_n}, 5'b11111);
    check("midop_rsp_valid", rsp_valid, 0);
    check("midop_busy", busy, 0);
    check("midop_req_ready", req_ready, 1);
    Reset = 1'b1;
    base = rise_cnt;
    repeat (30) tick();
    check("midop_no_rsp", rise_cnt - base, 0);
    check("midop_idle", busy, 0);

    // 6: WAIT_CYCLES=1 and 15 latency
    check("wc1_ready", req_ready_1, 1);
    req_valid_1 = 1'b1; req_addr_1 = 20'h00005;
    tick();
    base = cyc;
    req_valid_1 = 1'b0;
    g = 0;
    while (!rsp_valid_1 && g < 40) begin
      tick();
      g++;
    end
    check("latency_wc1", cyc - base, 3);
    check("data_wc1", rsp_data_1, 16'hA5A0);

    check("wc15_ready", req_ready_15, 1);
    req_valid_15 = 1'b1; req_addr_15 = 20'h00006;
    tick();
    base = cyc;
    req_valid_15 = 1'b0;
    g = 0;
    while (!rsp_valid_15 && g < 40) begin
      tick();
      g++;
    end
    check("latency_wc15", cyc - base, 17);
    check("data_wc15", rsp_data_15, 16'hA5A3);
    repeat (3) tick();

    check("we_n_constant", we_bad, 0);
    check("ub_lb_decode", ublb_bad, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
